// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the writeback stage, the register file and decode.
// Holds the writeback FSM state encoding and the default datapath/register
// index widths so all three agree on the same sizes.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Default datapath width and register index width.
  localparam int DEF_XLEN       = 32;
  localparam int DEF_ADDR_SIZE  = 5;
  // Default number of LD_WAIT cycles before a load is abandoned.
  localparam int DEF_LD_TIMEOUT = 15;

  // Writeback FSM states.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LD_WAIT = 1'b1
  } wb_state_e;

endpackage : cpu_pkg

// File: rtl/wb_ld_timer.sv
// -----------------------------------------------------------------------------
// wb_ld_timer
// Saturating cycle counter used to bound the time a load may wait for data.
//
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset (count -> 0)
//   clr_i in  synchronous clear, has priority over enable
//   en_i  in  count enable (increments by one, saturates at all-ones)
//   tc_o  out terminal count: high while the count equals LD_TIMEOUT-1
// -----------------------------------------------------------------------------
module wb_ld_timer #(
  parameter int LD_TIMEOUT = cpu_pkg::DEF_LD_TIMEOUT,
  localparam int CNT_W     = $clog2(LD_TIMEOUT) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(LD_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      // Saturate rather than wrap so a stuck count can never re-hit TC.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_TC);

endmodule : wb_ld_timer

// File: rtl/wb_unit.sv
// -----------------------------------------------------------------------------
// wb_unit
// Writeback stage. Accepts retired instructions from MEM, waits for load data
// when needed, drives the register file write port and provides the decode
// bypass that covers the regfile's write-then-read hole.
//
// Ports:
//   clk, rst              clock / asynchronous active-high reset
//   M_valid, M_ready      MEM handshake (ready only in IDLE)
//   M_we, M_ld, M_rd      instruction writes reg / is a load / destination
//   M_alu_res             result for non-loads
//   mem_rvalid, mem_rdata load data return
//   WB_we, WB_rd,         register file write port (one-cycle write pulses)
//   WB_data_mem
//   D_ra, D_rb            decode read indices
//   D_fwd_a_en/_b_en      decode should use D_fwd_data instead of regfile
//   D_fwd_data            bypass data (same as WB_data_mem)
//   ld_timeout_err        sticky: a load was abandoned, cleared by rst only
// -----------------------------------------------------------------------------
module wb_unit
  import cpu_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int LD_TIMEOUT = DEF_LD_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_valid,
  output logic                 M_ready,
  input  logic                 M_we,
  input  logic                 M_ld,
  input  logic [ADDR_SIZE-1:0] M_rd,
  input  logic [XLEN-1:0]      M_alu_res,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 WB_we,
  output logic [ADDR_SIZE-1:0] WB_rd,
  output logic [XLEN-1:0]      WB_data_mem,
  input  logic [ADDR_SIZE-1:0] D_ra,
  input  logic [ADDR_SIZE-1:0] D_rb,
  output logic                 D_fwd_a_en,
  output logic                 D_fwd_b_en,
  output logic [XLEN-1:0]      D_fwd_data,
  output logic                 ld_timeout_err
);

  wb_state_e state_q, state_d;

  logic                 wb_we_q,   wb_we_d;
  logic [ADDR_SIZE-1:0] wb_rd_q,   wb_rd_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic                 pend_we_q, pend_we_d;
  logic [ADDR_SIZE-1:0] pend_rd_q, pend_rd_d;
  logic                 err_q,     err_d;

  logic accept;
  logic timer_clr;
  logic timer_en;
  logic timer_tc;

  assign accept = M_valid && M_ready;

  // ---------------------------------------------------------------------------
  // Load wait timer: cleared on load accept, counts every LD_WAIT cycle that
  // has no data. TC marks the last allowed wait cycle.
  // ---------------------------------------------------------------------------
  assign timer_clr = accept && M_ld;
  assign timer_en  = (state_q == ST_LD_WAIT) && !mem_rvalid;

  wb_ld_timer #(
    .LD_TIMEOUT (LD_TIMEOUT)
  ) u_ld_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (timer_tc)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && M_ld) begin
          state_d = ST_LD_WAIT;
        end
      end
      ST_LD_WAIT: begin
        // Data arriving on the terminal-count cycle still completes the load.
        if (mem_rvalid || timer_tc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    M_ready = (state_q == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Writeback / pending-load / error next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_we_d   = 1'b0;          // writes are single-cycle pulses
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    pend_we_d = pend_we_q;
    pend_rd_d = pend_rd_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (M_ld) begin
            pend_we_d = M_we;
            pend_rd_d = M_rd;
          end else begin
            wb_we_d   = M_we && (M_rd != '0);
            wb_rd_d   = M_rd;
            wb_data_d = M_alu_res;
          end
        end
      end
      ST_LD_WAIT: begin
        if (mem_rvalid) begin
          wb_we_d   = pend_we_q && (pend_rd_q != '0);
          wb_rd_d   = pend_rd_q;
          wb_data_d = mem_rdata;
        end else if (timer_tc) begin
          // Load dropped: destination stays unwritten.
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      pend_we_q <= 1'b0;
      pend_rd_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      pend_we_q <= pend_we_d;
      pend_rd_q <= pend_rd_d;
      err_q     <= err_d;
    end
  end

  assign WB_we          = wb_we_q;
  assign WB_rd          = wb_rd_q;
  assign WB_data_mem    = wb_data_q;
  assign ld_timeout_err = err_q;

  // ---------------------------------------------------------------------------
  // Decode bypass. The regfile reads asynchronously and writes at the edge,
  // so a read of the register being written this cycle would see stale data.
  // Register 0 is hard-wired zero and is never forwarded.
  // ---------------------------------------------------------------------------
  assign D_fwd_data = wb_data_q;
  assign D_fwd_a_en = wb_we_q && (wb_rd_q == D_ra) && (wb_rd_q != '0);
  assign D_fwd_b_en = wb_we_q && (wb_rd_q == D_rb) && (wb_rd_q != '0);

endmodule : wb_unit

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid;
  logic        M_ready;
  logic        M_we;
  logic        M_ld;
  logic [4:0]  M_rd;
  logic [31:0] M_alu_res;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        WB_we;
  logic [4:0]  WB_rd;
  logic [31:0] WB_data_mem;
  logic [4:0]  D_ra;
  logic [4:0]  D_rb;
  logic        D_fwd_a_en;
  logic        D_fwd_b_en;
  logic [31:0] D_fwd_data;
  logic        ld_timeout_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  wb_unit #(
    .XLEN       (32),
    .ADDR_SIZE  (5),
    .LD_TIMEOUT (15)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .M_valid        (M_valid),
    .M_ready        (M_ready),
    .M_we           (M_we),
    .M_ld           (M_ld),
    .M_rd           (M_rd),
    .M_alu_res      (M_alu_res),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .WB_we          (WB_we),
    .WB_rd          (WB_rd),
    .WB_data_mem    (WB_data_mem),
    .D_ra           (D_ra),
    .D_rb           (D_rb),
    .D_fwd_a_en     (D_fwd_a_en),
    .D_fwd_b_en     (D_fwd_b_en),
    .D_fwd_data     (D_fwd_data),
    .ld_timeout_err (ld_timeout_err)
  );

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    M_valid    = 1'b0;
    M_we       = 1'b0;
    M_ld       = 1'b0;
    M_rd       = 5'd0;
    M_alu_res  = 32'd0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
  endtask

  task automatic drive_op(input logic ld, input logic [4:0] rd, input logic [31:0] res);
    M_valid   = 1'b1;
    M_we      = 1'b1;
    M_ld      = ld;
    M_rd      = rd;
    M_alu_res = res;
  endtask

  task automatic test_reset();
    drive_idle();
    D_ra = 5'd0;
    D_rb = 5'd0;
    rst  = 1'b1;
    #1;
    if (M_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", M_ready);
    else pass_cnt++;
    chk_cnt++;
    if (WB_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", WB_we);
    else pass_cnt++;
    chk_cnt++;
    if (WB_rd !== 5'd0 || WB_data_mem !== 32'd0)
      $display("FAIL reset_rd_data got rd=%0d data=%h exp rd=0 data=0", WB_rd, WB_data_mem);
    else pass_cnt++;
    chk_cnt++;
    if (ld_timeout_err !== 1'b0 || D_fwd_a_en !== 1'b0 || D_fwd_b_en !== 1'b0)
      $display("FAIL reset_err_fwd got err=%b a=%b b=%b exp 0/0/0", ld_timeout_err, D_fwd_a_en, D_fwd_b_en);
    else pass_cnt++;
    chk_cnt++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_alu_op();
    drive_op(1'b0, 5'd5, 32'h0000_1234);
    tick();
    drive_idle();
    D_ra = 5'd5;
    D_rb = 5'd6;
    #1;
    if (WB_we !== 1'b1 || WB_rd !== 5'd5 || WB_data_mem !== 32'h1234)
      $display("FAIL alu_write got we=%b rd=%0d data=%h exp we=1 rd=5 data=00001234", WB_we, WB_rd, WB_data_mem);
    else pass_cnt++;
    chk_cnt++;
    if (D_fwd_a_en !== 1'b1 || D_fwd_b_en !== 1'b0 || D_fwd_data !== 32'h1234)
      $display("FAIL alu_fwd got a=%b b=%b data=%h exp a=1 b=0 data=00001234", D_fwd_a_en, D_fwd_b_en, D_fwd_data);
    else pass_cnt++;
    chk_cnt++;
    tick();
    if (WB_we !== 1'b0 || D_fwd_a_en !== 1'b0 || WB_rd !== 5'd5 || WB_data_mem !== 32'h1234)
      $display("FAIL alu_pulse_end got we=%b a=%b rd=%0d data=%h exp we=0 a=0 rd=5 data=00001234",
               WB_we, D_fwd_a_en, WB_rd, WB_data_mem);
    else pass_cnt++;
    chk_cnt++;
    $display("txn alu r5 <= 00001234 we=%b", WB_we);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      drive_op(1'b0, 5'(i), 32'h100 + 32'(i));
      #1;
      if (M_ready !== 1'b1) $display("FAIL b2b_ready op=%0d got=%b exp=1", i, M_ready);
      else pass_cnt++;
      chk_cnt++;
      tick();
      if (WB_we !== 1'b1 || WB_rd !== 5'(i) || WB_data_mem !== 32'h100 + 32'(i))
        $display("FAIL b2b_write op=%0d got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h",
                 i, WB_we, WB_rd, WB_data_mem, i, 32'h100 + 32'(i));
      else pass_cnt++;
      chk_cnt++;
      $display("txn b2b r%0d <= %h", i, WB_data_mem);
    end
    drive_idle();
    tick();
    if (WB_we !== 1'b0) $display("FAIL b2b_end got we=%b exp=0", WB_we);
    else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_load();
    drive_op(1'b1, 5'd7, 32'h5555_5555);
    tick();                                   // now cycle N+1, in LD_WAIT
    // Offer an ALU op while busy: it must not be taken.
    drive_op(1'b0, 5'd9, 32'h9999);
    #1;
    if (M_ready !== 1'b0 || WB_we !== 1'b0)
      $display("FAIL load_wait1 got ready=%b we=%b exp ready=0 we=0", M_ready, WB_we);
    else pass_cnt++;
    chk_cnt++;
    tick();                                   // N+2
    drive_idle();
    if (M_ready !== 1'b0 || WB_we !== 1'b0)
      $display("FAIL load_wait2 got ready=%b we=%b exp ready=0 we=0", M_ready, WB_we);
    else pass_cnt++;
    chk_cnt++;
    tick();                                   // N+3: data arrives
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();                                   // N+4
    mem_rvalid = 1'b1;                        // rvalid in IDLE: ignored
    mem_rdata  = 32'h0000_CAFE;
    D_rb = 5'd7;
    #1;
    if (WB_we !== 1'b1 || WB_rd !== 5'd7 || WB_data_mem !== 32'hDEAD_BEEF || M_ready !== 1'b1)
      $display("FAIL load_write got we=%b rd=%0d data=%h ready=%b exp we=1 rd=7 data=deadbeef ready=1",
               WB_we, WB_rd, WB_data_mem, M_ready);
    else pass_cnt++;
    chk_cnt++;
    if (D_fwd_b_en !== 1'b1) $display("FAIL load_fwd_b got=%b exp=1", D_fwd_b_en);
    else pass_cnt++;
    chk_cnt++;
    tick();
    drive_idle();
    if (WB_we !== 1'b0 || WB_data_mem !== 32'hDEAD_BEEF || M_ready !== 1'b1)
      $display("FAIL idle_rvalid got we=%b data=%h ready=%b exp we=0 data=deadbeef ready=1",
               WB_we, WB_data_mem, M_ready);
    else pass_cnt++;
    chk_cnt++;
    $display("txn load r7 <= deadbeef");
  endtask

  task automatic test_r0();
    drive_op(1'b0, 5'd0, 32'hAAAA_AAAA);
    D_ra = 5'd0;
    tick();
    drive_idle();
    #1;
    if (WB_we !== 1'b0 || D_fwd_a_en !== 1'b0)
      $display("FAIL r0_write got we=%b a=%b exp we=0 a=0", WB_we, D_fwd_a_en);
    else pass_cnt++;
    chk_cnt++;
    $display("txn alu r0 suppressed");
  endtask

  task automatic test_timeout_race();
    int bad;
    bad = 0;
    drive_op(1'b1, 5'd4, 32'h0);
    tick();                                   // N+1
    drive_idle();
    for (int k = 2; k <= 15; k++) begin
      if (M_ready !== 1'b0 || WB_we !== 1'b0) bad++;
      tick();                                 // observing N+k
    end
    // Still in LD_WAIT during N+15 (the terminal-count cycle).
    if (M_ready !== 1'b0) bad++;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_BEEF;
    if (bad != 0) $display("FAIL race_wait got bad_cycles=%0d exp=0", bad);
    else pass_cnt++;
    chk_cnt++;
    tick();                                   // N+16
    drive_idle();
    if (WB_we !== 1'b1 || WB_rd !== 5'd4 || WB_data_mem !== 32'hBEEF || ld_timeout_err !== 1'b0 || M_ready !== 1'b1)
      $display("FAIL race_write got we=%b rd=%0d data=%h err=%b ready=%b exp we=1 rd=4 data=0000beef err=0 ready=1",
               WB_we, WB_rd, WB_data_mem, ld_timeout_err, M_ready);
    else pass_cnt++;
    chk_cnt++;
    tick();
    $display("txn load r4 <= 0000beef on terminal cycle");
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    drive_op(1'b1, 5'd10, 32'h0);
    tick();                                   // N+1
    drive_idle();
    for (int k = 2; k <= 16; k++) begin
      if (M_ready !== 1'b0 || WB_we !== 1'b0 || ld_timeout_err !== 1'b0) bad++;
      if (k <= 15) tick();
    end
    if (bad != 0) $display("FAIL timeout_wait got bad_cycles=%0d exp=0", bad);
    else pass_cnt++;
    chk_cnt++;
    tick();                                   // N+16
    if (ld_timeout_err !== 1'b1 || M_ready !== 1'b1 || WB_we !== 1'b0)
      $display("FAIL timeout_err got err=%b ready=%b we=%b exp err=1 ready=1 we=0",
               ld_timeout_err, M_ready, WB_we);
    else pass_cnt++;
    chk_cnt++;
    // Late load data plus a new ALU op in the same cycle.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    drive_op(1'b0, 5'd3, 32'h77);
    tick();
    drive_idle();
    if (WB_we !== 1'b1 || WB_rd !== 5'd3 || WB_data_mem !== 32'h77 || ld_timeout_err !== 1'b1)
      $display("FAIL timeout_next_op got we=%b rd=%0d data=%h err=%b exp we=1 rd=3 data=00000077 err=1",
               WB_we, WB_rd, WB_data_mem, ld_timeout_err);
    else pass_cnt++;
    chk_cnt++;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2222_2222;
    tick();
    drive_idle();
    if (WB_we !== 1'b0 || WB_data_mem !== 32'h77 || ld_timeout_err !== 1'b1)
      $display("FAIL timeout_late_rvalid got we=%b data=%h err=%b exp we=0 data=00000077 err=1",
               WB_we, WB_data_mem, ld_timeout_err);
    else pass_cnt++;
    chk_cnt++;
    $display("txn load r10 timed out err=%b", ld_timeout_err);
  endtask

  task automatic test_reset_mid_load();
    drive_op(1'b1, 5'd6, 32'h0);
    tick();
    drive_idle();
    tick();
    #2;
    rst = 1'b1;
    #1;
    if (M_ready !== 1'b1 || WB_we !== 1'b0 || WB_rd !== 5'd0 || WB_data_mem !== 32'd0 || ld_timeout_err !== 1'b0)
      $display("FAIL rst_mid got ready=%b we=%b rd=%0d data=%h err=%b exp ready=1 we=0 rd=0 data=0 err=0",
               M_ready, WB_we, WB_rd, WB_data_mem, ld_timeout_err);
    else pass_cnt++;
    chk_cnt++;
    #1;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0099;
    tick();
    drive_idle();
    if (WB_we !== 1'b0 || WB_data_mem !== 32'd0 || M_ready !== 1'b1)
      $display("FAIL rst_mid_rvalid got we=%b data=%h ready=%b exp we=0 data=0 ready=1",
               WB_we, WB_data_mem, M_ready);
    else pass_cnt++;
    chk_cnt++;
    $display("txn reset during load, pending r6 discarded");
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_back_to_back();
    test_load();
    test_r0();
    test_timeout_race();
    test_timeout();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_wb_unit

// File: doc/wb_unit.md
# wb_unit

Writeback stage of the pipeline: accepts retired instructions from the MEM stage, waits for load data from data memory, and drives the register file write port (`WB_we`/`WB_rd`/`WB_data_mem`). The register file writes on the clock edge and reads asynchronously, so a same-cycle read returns stale data. This block therefore also provides the decode-side bypass that closes that write-then-read hole. It sits between the MEM stage/data memory and the register file plus decode.

## Interface
- `XLEN`, 32, datapath width
- `ADDR_SIZE`, 5, register index width
- `LD_TIMEOUT`, 15, max cycles spent in LD_WAIT before abort (≥1)

- `clk` in 1 — clock, rising edge
- `rst` in 1 — reset, asynchronous, active-high
- `M_valid` in 1 — MEM stage presents an instruction
- `M_ready` out 1 — block accepts this cycle
- `M_we` in 1 — instruction writes a register
- `M_ld` in 1 — instruction is a load (result comes from `mem_rdata`)
- `M_rd` in ADDR_SIZE — destination register
- `M_alu_res` in XLEN — result for non-loads
- `mem_rvalid` in 1 — load data valid
- `mem_rdata` in XLEN — load data
- `WB_we` out 1 — register file write enable
- `WB_rd` out ADDR_SIZE — register file write index
- `WB_data_mem` out XLEN — register file write data
- `D_ra`, `D_rb` in ADDR_SIZE — decode read indices
- `D_fwd_a_en`, `D_fwd_b_en` out 1 — decode must take `D_fwd_data` instead of the regfile value
- `D_fwd_data` out XLEN — bypass data; always equals `WB_data_mem`
- `ld_timeout_err` out 1 — sticky load-timeout flag

## Operation
- FSM with two states: IDLE and LD_WAIT. `M_ready` = (state == IDLE).
- Accept = `M_valid && M_ready`.
- Accept with `!M_ld`:
  - At the next edge: `WB_we <= M_we && (M_rd != 0)`, `WB_rd <= M_rd`, `WB_data_mem <= M_alu_res`.
  - State stays IDLE.
- Accept with `M_ld`:
  - Latch `M_rd` and `M_we` into a pending register, clear the timeout counter, go to LD_WAIT.
  - `WB_we <= 0` at that edge.
- In LD_WAIT with `mem_rvalid`:
  - At the next edge: `WB_we <= pend_we && pend_rd != 0`, `WB_rd <= pend_rd`, `WB_data_mem <= mem_rdata`.
  - Return to IDLE.
- In LD_WAIT without `mem_rvalid`:
  - Counter increments.
  - When the counter equals `LD_TIMEOUT-1`, the edge sets `ld_timeout_err <= 1`, `WB_we <= 0`, and returns to IDLE. The load is dropped and the destination is left unwritten.
- `mem_rvalid` in IDLE is ignored. There is no state change and no write.
- `mem_rvalid` in the same cycle as the timeout edge: data wins, the write happens, and no error is raised.
- No accept in IDLE: `WB_we <= 0` (one-cycle write pulses). `WB_rd` and `WB_data_mem` hold their last values.
- Bypass is combinational:
  - `D_fwd_a_en = WB_we && (WB_rd == D_ra) && (WB_rd != 0)`; same for b with `D_rb`.
  - Register 0 is never forwarded.
- `ld_timeout_err` clears only on `rst`.
- Counter width is `$clog2(LD_TIMEOUT)+1` bits. The counter saturates and never wraps.

## Timing
- Reset values: state IDLE, `M_ready`=1, `WB_we`=0, `WB_rd`=0, `WB_data_mem`=0, `ld_timeout_err`=0, counter 0, pending reg 0. `D_fwd_*_en`=0 follows from `WB_we`=0.
- Non-load latency: accept at cycle N → `WB_we` high during N+1. The register file commits at the end of N+1. Full throughput, one per cycle.
- Load: accept at N → earliest `mem_rvalid` at N+1.
  - `mem_rvalid` at cycle K → `WB_we` high during K+1, and `M_ready` high during K+1.
  - Minimum load occupancy is 2 cycles.
- Timeout: with no `mem_rvalid`, the return to IDLE happens at the edge ending cycle N+LD_TIMEOUT.
- Reset asserted mid-LD_WAIT: immediate return to reset values. The pending load is discarded, and a later `mem_rvalid` is ignored.

## Structure
- Shared package/header `cpu_pkg`: FSM state encodings (IDLE=0, LD_WAIT=1) and the `XLEN`/`ADDR_SIZE` defaults shared with the register file and decode.
- One sub-module, `wb_ld_timer`: a saturating counter with clear/enable and a terminal-count output at `LD_TIMEOUT-1`.
- Everything else lives inline in `wb_unit`.

## Test plan
- Reset, then ALU op with `M_rd`=5 and `M_alu_res`=0x1234 accepted at cycle 1 → `WB_we`=1, `WB_rd`=5, `WB_data_mem`=0x1234 during cycle 2 only. With `D_ra`=5 in cycle 2 → `D_fwd_a_en`=1, `D_fwd_data`=0x1234.
- Three back-to-back ALU ops to r1, r2, r3 → three consecutive `WB_we` pulses. `M_ready` stays 1 throughout.
- Load to r7 accepted, `mem_rvalid` 3 cycles later with 0xDEADBEEF → `M_ready`=0 while waiting; one write of 0xDEADBEEF to r7 the cycle after rvalid; `M_ready` returns to 1 that same cycle.
- Op with `M_rd`=0, `M_we`=1, plus `D_ra`=0 → `WB_we` stays 0, `D_fwd_a_en`=0.
- Load with no `mem_rvalid` at `LD_TIMEOUT`=15 → `ld_timeout_err` rises after 15 wait cycles and stays high, no write occurs, and the next ALU op is accepted. A late `mem_rvalid` is ignored.
- `rst` pulsed during LD_WAIT, then `mem_rvalid` → all outputs at reset values, no write, state IDLE.
